// File: rtl/mbinit_substate_ctrl.sv
// MBINIT substate sequencer: walks PARAM..REPAIRMB in order, enabling one
// substate engine at a time. It watches that engine's done/error, enforces a
// per-substate residency timeout and a bounded number of REPAIRMB retries,
// and reports overall completion or failure to the LTSM.
//
// Handshake: substate_en_o is a level held for the whole residency of a
// substate; the engine answers by raising done or err for the active bit only.
// A one-cycle enable-low gap separates consecutive enables (including a REPAIRMB
// retry) so every engine sees a fresh rising enable; inputs are ignored in the gap.
module mbinit_substate_ctrl #(
    parameter int TIMEOUT_CYCLES = 800000,
    parameter int MAX_RETRY      = 2,
    parameter int CNT_W          = 20
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       enable_i,
    output logic [5:0] substate_en_o,
    input  logic [5:0] substate_done_i,
    input  logic [5:0] substate_err_i,
    input  logic       repair_retry_i,
    output logic       MBINIT_done_o,
    output logic       MBINIT_error_o,
    output logic [2:0] err_code_o,
    output logic [2:0] cur_substate_o
);

    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

    localparam logic [2:0] CODE_NONE    = 3'd0;
    localparam logic [2:0] CODE_SUBERR  = 3'd1;
    localparam logic [2:0] CODE_TIMEOUT = 3'd2;
    localparam logic [2:0] CODE_RETRY   = 3'd3;

    // Low three bits double as the debug encoding; FAIL reports as 0.
    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_PARAM      = 4'd1,
        ST_CAL        = 4'd2,
        ST_REPAIRCLK  = 4'd3,
        ST_REPAIRVAL  = 4'd4,
        ST_REVERSALMB = 4'd5,
        ST_REPAIRMB   = 4'd6,
        ST_DONE       = 4'd7,
        ST_FAIL       = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic             gap_q, gap_d;     // enable suppressed for one cycle
    logic [CNT_W-1:0] tcnt_q, tcnt_d;   // residency timer of active substate
    logic [RTY_W-1:0] rcnt_q, rcnt_d;   // REPAIRMB re-runs taken so far
    logic [2:0]       code_q, code_d;

    logic       active;
    logic [5:0] sel;
    logic       sub_done;
    logic       sub_err;

    // Decode the active substate into a one-hot select and qualify its inputs.
    always_comb begin
        active   = (state_q >= ST_PARAM) && (state_q <= ST_REPAIRMB);
        sel      = active ? (6'b000001 << (state_q[2:0] - 3'd1)) : 6'b000000;
        sub_done = |(substate_done_i & sel);
        sub_err  = |(substate_err_i & sel);
    end

    assign substate_en_o  = gap_q ? 6'b000000 : sel;
    assign MBINIT_done_o  = (state_q == ST_DONE) && !gap_q;
    assign MBINIT_error_o = (state_q == ST_FAIL);
    assign err_code_o     = code_q;
    assign cur_substate_o = (state_q == ST_FAIL) ? 3'd0 : state_q[2:0];

    // Next-state logic: abort, error, done, retry, timeout in priority order.
    always_comb begin
        state_d = state_q;
        gap_d   = 1'b0;
        tcnt_d  = tcnt_q;
        rcnt_d  = rcnt_q;
        code_d  = code_q;
        case (state_q)
            ST_IDLE: begin
                tcnt_d = '0;
                rcnt_d = '0;
                code_d = CODE_NONE;
                if (enable_i) state_d = ST_PARAM;
            end
            ST_DONE, ST_FAIL: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                    code_d  = CODE_NONE;
                end
            end
            default: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                    tcnt_d  = '0;
                    rcnt_d  = '0;
                    code_d  = CODE_NONE;
                end else if (gap_q) begin
                    tcnt_d = '0;
                end else if (sub_err) begin
                    state_d = ST_FAIL;
                    code_d  = CODE_SUBERR;
                end else if (sub_done) begin
                    // REPAIRMB + 1 lands on DONE, which also waits out one gap.
                    state_d = state_t'(state_q + 4'd1);
                    gap_d   = 1'b1;
                    tcnt_d  = '0;
                end else if ((state_q == ST_REPAIRMB) && repair_retry_i) begin
                    if (rcnt_q == RTY_MAX) begin
                        state_d = ST_FAIL;
                        code_d  = CODE_RETRY;
                    end else begin
                        gap_d  = 1'b1;
                        rcnt_d = rcnt_q + 1'b1;
                        tcnt_d = '0;
                    end
                end else if (tcnt_q == TO_LAST) begin
                    state_d = ST_FAIL;
                    code_d  = CODE_TIMEOUT;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gap_q   <= 1'b0;
            tcnt_q  <= '0;
            rcnt_q  <= '0;
            code_q  <= CODE_NONE;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            tcnt_q  <= tcnt_d;
            rcnt_q  <= rcnt_d;
            code_q  <= code_d;
        end
    end

endmodule

// File: tb/tb_mbinit_substate_ctrl.sv
// Bench for mbinit_substate_ctrl. Inputs change and outputs are observed 1 ns
// after each rising edge; an input set after an observation is taken by the
// following edge.
module tb_mbinit_substate_ctrl;

    localparam int TO  = 100;
    localparam int MXR = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable_i;
    logic [5:0] substate_en_o;
    logic [5:0] substate_done_i;
    logic [5:0] substate_err_i;
    logic       repair_retry_i;
    logic       MBINIT_done_o;
    logic       MBINIT_error_o;
    logic [2:0] err_code_o;
    logic [2:0] cur_substate_o;

    int n_checks = 0;
    int n_fail   = 0;

    mbinit_substate_ctrl #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MXR), .CNT_W(20)) dut (
        .clk_100MHz     (clk),
        .reset          (reset),
        .enable_i       (enable_i),
        .substate_en_o  (substate_en_o),
        .substate_done_i(substate_done_i),
        .substate_err_i (substate_err_i),
        .repair_retry_i (repair_retry_i),
        .MBINIT_done_o  (MBINIT_done_o),
        .MBINIT_error_o (MBINIT_error_o),
        .err_code_o     (err_code_o),
        .cur_substate_o (cur_substate_o)
    );

    // Clock and reset block
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        substate_done_i = '0;
        substate_err_i  = '0;
        repair_retry_i  = 1'b0;
    endtask

    // Driver: enter MBINIT from IDLE and complete substates 0..k-1 with short
    // random engine delays; returns at the first observed cycle of substate k.
    task automatic advance_to(input int k);
        int d;
        enable_i = 1'b1;
        for (int s = 0; s < k; s++) begin
            d = $urandom_range(1, 4);
            repeat (d) tick();
            substate_done_i = 6'b000001 << s;
            tick();
            substate_done_i = '0;
        end
        tick();
    endtask

    // Driver: leave MBINIT and return to IDLE.
    task automatic leave();
        clear_inputs();
        enable_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable_i = 1'b0;
        clear_inputs();
        tick();
        tick();
        n_checks++;
        if ({substate_en_o, MBINIT_done_o, MBINIT_error_o, err_code_o, cur_substate_o} !== 14'b0) begin
            n_fail++;
            $display("FAIL reset_state: got en=%h done=%b err=%b code=%0d cur=%0d, expected all 0",
                     substate_en_o, MBINIT_done_o, MBINIT_error_o, err_code_o, cur_substate_o);
        end
        reset = 1'b0;
        tick();
    endtask

    // Randomized full runs. The reference model is an expected per-cycle
    // trace built from the sequencing rules: each substate holds its one-hot
    // enable for exactly the engine delay, then one gap cycle of zero.
    // Inactive-substate inputs and gap-cycle inputs are randomized noise.
    task automatic test_happy(input int iters);
        logic [5:0] exp_q[$];
        logic [2:0] cur_q[$];
        logic [5:0] dn_q[$];
        logic [5:0] er_q[$];
        logic       rt_q[$];
        logic [5:0] oh;
        int         d;
        for (int it = 0; it < iters; it++) begin
            exp_q.delete(); cur_q.delete(); dn_q.delete(); er_q.delete(); rt_q.delete();
            for (int k = 0; k < 6; k++) begin
                oh = 6'b000001 << k;
                d  = $urandom_range(1, 12);
                for (int c = 0; c < d; c++) begin
                    exp_q.push_back(oh);
                    cur_q.push_back(3'(k + 1));
                    dn_q.push_back(((c == d - 1) ? oh : 6'b0) | (6'($urandom) & ~oh));
                    er_q.push_back(6'($urandom) & 6'($urandom) & ~oh);
                    rt_q.push_back((k == 5) ? 1'b0 : 1'($urandom));
                end
                exp_q.push_back(6'b0);
                cur_q.push_back(3'd0);
                dn_q.push_back(6'($urandom));
                er_q.push_back(6'($urandom));
                rt_q.push_back(1'($urandom));
            end
            clear_inputs();
            enable_i = 1'b1;
            for (int i = 0; i < exp_q.size(); i++) begin
                tick();
                n_checks++;
                if (substate_en_o !== exp_q[i] || MBINIT_done_o !== 1'b0 || MBINIT_error_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL happy_en it%0d cyc%0d: got en=%h done=%b err=%b, expected en=%h done=0 err=0",
                             it, i, substate_en_o, MBINIT_done_o, MBINIT_error_o, exp_q[i]);
                end
                if (exp_q[i] != 6'b0) begin
                    n_checks++;
                    if (cur_substate_o !== cur_q[i]) begin
                        n_fail++;
                        $display("FAIL happy_cur it%0d cyc%0d: got %0d expected %0d", it, i, cur_substate_o, cur_q[i]);
                    end
                end
                substate_done_i = dn_q[i];
                substate_err_i  = er_q[i];
                repair_retry_i  = rt_q[i];
            end
            tick();
            n_checks++;
            if (MBINIT_done_o !== 1'b1 || MBINIT_error_o !== 1'b0 || substate_en_o !== 6'b0 ||
                cur_substate_o !== 3'd7 || err_code_o !== 3'd0) begin
                n_fail++;
                $display("FAIL happy_done it%0d: got done=%b err=%b en=%h cur=%0d code=%0d, expected 1 0 00 7 0",
                         it, MBINIT_done_o, MBINIT_error_o, substate_en_o, cur_substate_o, err_code_o);
            end
            leave();
            n_checks++;
            if (MBINIT_done_o !== 1'b0 || cur_substate_o !== 3'd0 || substate_en_o !== 6'b0) begin
                n_fail++;
                $display("FAIL happy_exit it%0d: got done=%b cur=%0d en=%h, expected 0 0 00",
                         it, MBINIT_done_o, cur_substate_o, substate_en_o);
            end
        end
    endtask

    task automatic test_timeout();
        // CAL never answers: error exactly TO cycles after the first CAL enable.
        advance_to(1);
        for (int j = 0; j < TO; j++) begin
            n_checks++;
            if (substate_en_o !== 6'h02 || MBINIT_error_o !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_wait cyc%0d: got en=%h err=%b expected 02 0", j, substate_en_o, MBINIT_error_o);
            end
            substate_done_i = 6'($urandom) & 6'b111101;
            tick();
        end
        n_checks++;
        if (MBINIT_error_o !== 1'b1 || err_code_o !== 3'd2 || substate_en_o !== 6'b0 ||
            MBINIT_done_o !== 1'b0 || cur_substate_o !== 3'd0) begin
            n_fail++;
            $display("FAIL timeout_fire: got err=%b code=%0d en=%h done=%b cur=%0d, expected 1 2 00 0 0",
                     MBINIT_error_o, err_code_o, substate_en_o, MBINIT_done_o, cur_substate_o);
        end
        clear_inputs();
        substate_done_i = 6'h3f;
        repeat (5) tick();
        n_checks++;
        if (MBINIT_error_o !== 1'b1 || err_code_o !== 3'd2) begin
            n_fail++;
            $display("FAIL timeout_hold: got err=%b code=%0d expected 1 2", MBINIT_error_o, err_code_o);
        end
        leave();
        n_checks++;
        if (MBINIT_error_o !== 1'b0 || err_code_o !== 3'd0) begin
            n_fail++;
            $display("FAIL timeout_clear: got err=%b code=%0d expected 0 0", MBINIT_error_o, err_code_o);
        end
        // Done arriving on the last timeout cycle wins over the timeout.
        advance_to(1);
        repeat (TO - 1) tick();
        substate_done_i = 6'h02;
        tick();
        substate_done_i = '0;
        n_checks++;
        if (MBINIT_error_o !== 1'b0 || substate_en_o !== 6'b0) begin
            n_fail++;
            $display("FAIL done_vs_timeout_gap: got err=%b en=%h expected 0 00", MBINIT_error_o, substate_en_o);
        end
        tick();
        n_checks++;
        if (substate_en_o !== 6'h04 || cur_substate_o !== 3'd3) begin
            n_fail++;
            $display("FAIL done_vs_timeout_next: got en=%h cur=%0d expected 04 3", substate_en_o, cur_substate_o);
        end
        leave();
    endtask

    task automatic test_collision();
        int seen_rev;
        advance_to(3);
        repeat ($urandom_range(0, 5)) tick();
        substate_done_i = 6'h08;
        substate_err_i  = 6'h08;
        tick();
        clear_inputs();
        n_checks++;
        if (MBINIT_error_o !== 1'b1 || err_code_o !== 3'd1 || substate_en_o !== 6'b0) begin
            n_fail++;
            $display("FAIL collision_fail: got err=%b code=%0d en=%h expected 1 1 00",
                     MBINIT_error_o, err_code_o, substate_en_o);
        end
        seen_rev = 0;
        for (int j = 0; j < 20; j++) begin
            substate_done_i = 6'($urandom);
            tick();
            if (substate_en_o[4]) seen_rev++;
        end
        n_checks++;
        if (seen_rev != 0 || MBINIT_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_no_rev: got %0d REVERSALMB enables done=%b, expected 0 0", seen_rev, MBINIT_done_o);
        end
        leave();
    endtask

    task automatic test_retry();
        advance_to(5);
        for (int r = 0; r < MXR; r++) begin
            repeat ($urandom_range(0, 5)) tick();
            n_checks++;
            if (substate_en_o !== 6'h20) begin
                n_fail++;
                $display("FAIL retry_active r%0d: got en=%h expected 20", r, substate_en_o);
            end
            repair_retry_i = 1'b1;
            tick();
            repair_retry_i = 1'b0;
            n_checks++;
            if (substate_en_o !== 6'b0 || MBINIT_error_o !== 1'b0) begin
                n_fail++;
                $display("FAIL retry_drop r%0d: got en=%h err=%b expected 00 0", r, substate_en_o, MBINIT_error_o);
            end
            tick();
            n_checks++;
            if (substate_en_o !== 6'h20 || cur_substate_o !== 3'd6) begin
                n_fail++;
                $display("FAIL retry_reenter r%0d: got en=%h cur=%0d expected 20 6", r, substate_en_o, cur_substate_o);
            end
        end
        repair_retry_i = 1'b1;
        tick();
        repair_retry_i = 1'b0;
        n_checks++;
        if (MBINIT_error_o !== 1'b1 || err_code_o !== 3'd3 || substate_en_o !== 6'b0) begin
            n_fail++;
            $display("FAIL retry_exhaust: got err=%b code=%0d en=%h expected 1 3 00",
                     MBINIT_error_o, err_code_o, substate_en_o);
        end
        leave();
        // Fresh entry gets fresh retries: one retry then normal completion.
        advance_to(5);
        repair_retry_i = 1'b1;
        tick();
        repair_retry_i = 1'b0;
        tick();
        n_checks++;
        if (substate_en_o !== 6'h20 || MBINIT_error_o !== 1'b0) begin
            n_fail++;
            $display("FAIL retry_fresh: got en=%h err=%b expected 20 0", substate_en_o, MBINIT_error_o);
        end
        substate_done_i = 6'h20;
        tick();
        substate_done_i = '0;
        tick();
        n_checks++;
        if (MBINIT_done_o !== 1'b1 || MBINIT_error_o !== 1'b0 || err_code_o !== 3'd0) begin
            n_fail++;
            $display("FAIL retry_followup_done: got done=%b err=%b code=%0d expected 1 0 0",
                     MBINIT_done_o, MBINIT_error_o, err_code_o);
        end
        leave();
    endtask

    task automatic test_abort_reset();
        advance_to(4);
        repeat ($urandom_range(0, 5)) tick();
        enable_i = 1'b0;
        tick();
        n_checks++;
        if ({substate_en_o, MBINIT_done_o, MBINIT_error_o, err_code_o, cur_substate_o} !== 14'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got en=%h done=%b err=%b code=%0d cur=%0d, expected all 0",
                     substate_en_o, MBINIT_done_o, MBINIT_error_o, err_code_o, cur_substate_o);
        end
        advance_to(0);
        repeat ($urandom_range(0, 5)) tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if ({substate_en_o, MBINIT_done_o, MBINIT_error_o, err_code_o, cur_substate_o} !== 14'b0) begin
            n_fail++;
            $display("FAIL reset_mid_param: got en=%h done=%b err=%b code=%0d cur=%0d, expected all 0",
                     substate_en_o, MBINIT_done_o, MBINIT_error_o, err_code_o, cur_substate_o);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (substate_en_o !== 6'h01 || cur_substate_o !== 3'd1) begin
            n_fail++;
            $display("FAIL reset_restart: got en=%h cur=%0d expected 01 1", substate_en_o, cur_substate_o);
        end
        leave();
    endtask

    task automatic test_stray();
        advance_to(0);
        substate_done_i = 6'h20;
        substate_err_i  = 6'h04;
        tick();
        clear_inputs();
        n_checks++;
        if (substate_en_o !== 6'h01 || cur_substate_o !== 3'd1 || MBINIT_error_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_plan: got en=%h cur=%0d err=%b expected 01 1 0",
                     substate_en_o, cur_substate_o, MBINIT_error_o);
        end
        for (int j = 0; j < 30; j++) begin
            substate_done_i = 6'($urandom) & 6'b111110;
            substate_err_i  = 6'($urandom) & 6'b111110;
            repair_retry_i  = 1'($urandom);
            tick();
            n_checks++;
            if (substate_en_o !== 6'h01 || MBINIT_error_o !== 1'b0) begin
                n_fail++;
                $display("FAIL stray_rand cyc%0d: got en=%h err=%b expected 01 0", j, substate_en_o, MBINIT_error_o);
            end
        end
        clear_inputs();
        substate_done_i = 6'h01;
        tick();
        substate_done_i = '0;
        tick();
        n_checks++;
        if (substate_en_o !== 6'h02) begin
            n_fail++;
            $display("FAIL stray_then_cal: got en=%h expected 02", substate_en_o);
        end
        leave();
    endtask

    initial begin
        reset = 1'b1;
        enable_i = 1'b0;
        clear_inputs();
        test_reset();
        test_happy(4);
        test_timeout();
        test_collision();
        test_retry();
        test_abort_reset();
        test_stray();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mbinit_substate_ctrl.md
Name: mbinit_substate_ctrl

Overview:
- Sequencer for the mainband initialisation phase of the LTSM.
- Steps through the MBINIT substates in fixed order: PARAM, CAL, REPAIRCLK, REPAIRVAL, REVERSALMB, REPAIRMB. For each substate it drives a one-hot enable to the substate engine and waits for that engine's done or error.
- Enforces the 8 ms per-substate residency timeout and allows a bounded number of REPAIRMB retries.
- Reports MBINIT completion or failure (to TRAINERROR) to the top-level LTSM.

Parameters:
- TIMEOUT_CYCLES, 800000, per-substate timeout in clk_100MHz cycles (8 ms).
- MAX_RETRY, 2, number of REPAIRMB re-runs permitted after a repair request.
- CNT_W, 20, width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_100MHz  in  1  sideband-domain clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- enable_i  in  1  MBINIT entered. Level; must stay high for the whole phase.
- substate_en_o  out  6  one-hot substate enable. bit0=PARAM, 1=CAL, 2=REPAIRCLK, 3=REPAIRVAL, 4=REVERSALMB, 5=REPAIRMB.
- substate_done_i  in  6  per-substate done pulse or level; sampled only for the active substate.
- substate_err_i  in  6  per-substate error; sampled only for the active substate.
- repair_retry_i  in  1  REPAIRMB requests re-run after lane remap; sampled only in REPAIRMB.
- MBINIT_done_o  out  1  MBINIT complete. Level, held while enable_i stays high.
- MBINIT_error_o  out  1  MBINIT failed; LTSM goes to TRAINERROR. Level, held while enable_i stays high.
- err_code_o  out  3  failure cause: 0=none, 1=substate error, 2=timeout, 3=retry exhausted.
- cur_substate_o  out  3  debug encoding of the current state (encodings below).

Behaviour:
- State encoding: IDLE=0, PARAM=1, CAL=2, REPAIRCLK=3, REPAIRVAL=4, REVERSALMB=5, REPAIRMB=6, DONE=7. FAIL is internal and reports cur_substate_o=0 with MBINIT_error_o=1.
- Reset values:
  - state IDLE; all outputs 0; timeout counter 0; retry counter 0.
- IDLE:
  - enable_i=1 -> PARAM on the next edge.
  - substate_en_o becomes 000001 in the same cycle that state becomes PARAM. Enable is registered and decoded from state.
- Active substate S (PARAM..REPAIRMB):
  - substate_en_o has only bit S set.
  - The timeout counter increments each cycle; it is cleared on every substate entry.
  - Priority within a cycle, highest first:
    1. enable_i=0 -> IDLE.
    2. substate_err_i[S]=1 -> FAIL, code 1.
    3. substate_done_i[S]=1 -> next substate (REPAIRMB -> DONE).
    4. In REPAIRMB only: repair_retry_i=1 -> re-enter REPAIRMB, or FAIL with code 3 if the retry count already equals MAX_RETRY.
    5. Counter == TIMEOUT_CYCLES-1 -> FAIL, code 2.
  - Done and error asserted together: error wins.
  - Done on the timeout cycle: done wins.
- Re-entering REPAIRMB:
  - substate_en_o drops to 0 for exactly 1 cycle, then bit5 re-asserts, so the engine sees a fresh rising enable.
  - The retry counter increments; the timeout counter clears.
- Transition gap: one cycle between substates with substate_en_o=0. Done/err inputs are ignored in that cycle.
- DONE:
  - MBINIT_done_o=1 and substate_en_o=0.
  - Stays until enable_i=0, then goes to IDLE with MBINIT_done_o=0 on the next edge.
- FAIL:
  - MBINIT_error_o=1, err_code_o latched, substate_en_o=0.
  - Stays until enable_i=0, then goes to IDLE and clears error and code.
- MBINIT_done_o and MBINIT_error_o are never both 1.
- Latency: IDLE to PARAM enable is 1 cycle. Substate done to next enable is 2 cycles (done edge, gap cycle, enable).
- Retry counter clears on IDLE entry only, so a full MBINIT restart gets fresh retries.
- Reset mid-operation: everything returns to the reset values on the next edge, regardless of state.
- Inputs for inactive substates are ignored entirely.

Test Plan:
- Happy path:
  - Stimulus: enable_i=1; each engine pulses done 10 cycles after its enable.
  - Required: substate_en_o goes 01,02,04,08,10,20 (hex), separated by 1-cycle gaps; cur_substate_o goes 1..6 then 7; MBINIT_done_o=1 exactly 2 cycles after the REPAIRMB done; err_code_o=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=100; CAL never signals done.
  - Required: MBINIT_error_o=1 and err_code_o=2 exactly 100 cycles after CAL entry; substate_en_o=0.
- Error vs done collision:
  - Stimulus: in REPAIRVAL, assert substate_done_i[3] and substate_err_i[3] in the same cycle.
  - Required: FAIL with code 1; no REVERSALMB enable ever appears.
- Retry bound:
  - Stimulus: MAX_RETRY=2; in REPAIRMB pulse repair_retry_i three times.
  - Required: two re-entries, each preceded by a 1-cycle enable drop; the third request gives FAIL with code 3.
  - Follow-up: deassert and reassert enable_i, complete all substates normally -> MBINIT_done_o=1 (retry count was cleared).
- Abort and reset:
  - Stimulus: drop enable_i mid-REVERSALMB -> required: IDLE next edge, all outputs 0.
  - Stimulus: assert reset mid-PARAM -> required: IDLE and all outputs 0 on the next edge.
- Stray inputs:
  - Stimulus: during PARAM, pulse substate_done_i[5] and substate_err_i[2].
  - Required: no state change.
